mapper_switch: RTL

Clock-domain mapper selection controller for the cartridge FPGA, sitting between the host register port and the mapper mux. It decodes host register writes and stages mapper and CHR/PRG layout settings. It commits those settings atomically when the CPU fetches the reset vector, and it detects CPU reset by M2 inactivity. It also issues SDRAM refresh requests through a req/ack handshake and assembles the status word. It generalises the mapper count, address width and timing constants, and adds switch timeout, write validation and refresh-overrun accounting.

---
 rtl/mapper_switch.sv | 254 +++++++++++++++++++++++++
 1 files changed

// File: rtl/mapper_switch.sv
// mapper_switch: host-register-driven mapper selection with atomic commit on
// the CPU reset-vector fetch, M2-idle CPU reset detection, SDRAM refresh
// request handshake and status word assembly.
module mapper_switch #(
  parameter int unsigned MAP_CNT        = 32,
  parameter int unsigned MAP_BITS       = 5,
  parameter int unsigned ADDR_BITS      = 23,
  parameter int unsigned RESET_TICKS    = 255,
  parameter int unsigned SWITCH_TIMEOUT = 4096,
  parameter int unsigned REFRESH_DELAY  = 2
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 m2,
  input  logic [15:0]          cpu_addr,
  input  logic [7:0]           cpu_data,
  input  logic                 cpu_rw,
  input  logic [11:0]          wr_reg,
  input  logic [3:0]           wr_reg_addr,
  input  logic                 wr_reg_valid,
  input  logic [8:0]           launcher_status,
  input  logic                 refresh_ack,
  output logic [MAP_BITS-1:0]  select,
  output logic [1:0]           map_args,
  output logic [ADDR_BITS-1:0] prg_mask,
  output logic [ADDR_BITS-1:0] chr_base,
  output logic                 cpu_reset,
  output logic                 launcher_load,
  output logic                 launcher_halt,
  output logic                 launcher_buffer_num,
  output logic                 refresh_req,
  output logic [31:0]          status_reg
);

  localparam int unsigned RST_W = $clog2(RESET_TICKS + 1);
  localparam int unsigned TMO_W = $clog2(SWITCH_TIMEOUT + 1);
  localparam int unsigned DLY_W = $clog2(REFRESH_DELAY + 1);

  typedef enum logic [1:0] {ST_IDLE, ST_PENDING, ST_COMMIT} state_t;

  state_t               state, state_next;
  logic [2:0]           m2_sync;
  logic                 m2_fall;
  logic [15:0]          lat_addr;
  logic [7:0]           lat_data;
  logic                 lat_rw;
  logic                 saw_fffc;
  logic                 vec_hit;
  logic [RST_W-1:0]     rst_cnt;
  logic                 cpu_reset_q;
  logic                 cpu_reset_rise;
  logic [TMO_W-1:0]     tmo_cnt;
  logic                 tmo_fire;
  logic [4:0]           wr_sel;
  logic [4:0]           wr_off;
  logic                 wr_map, wr_ok, wr_accept, wr_reject, wr_launch;
  logic [MAP_BITS-1:0]  stg_sel;
  logic [4:0]           stg_off;
  logic [1:0]           stg_args;
  logic [ADDR_BITS-1:0] cm_mask, cm_base;
  logic                 do_commit;
  logic                 tmo_err, rej_err;
  logic [3:0]           ovr_cnt;
  logic [DLY_W-1:0]     dly_cnt;
  logic [8:0]           lstat;

  assign m2_fall        = m2_sync[2] & ~m2_sync[1];
  assign cpu_reset      = (rst_cnt == RST_W'(RESET_TICKS));
  assign cpu_reset_rise = cpu_reset & ~cpu_reset_q;

  assign wr_sel    = wr_reg[4:0];
  assign wr_off    = wr_reg[9:5];
  assign wr_map    = wr_reg_valid && (wr_reg_addr == 4'd0);
  assign wr_launch = wr_reg_valid && (wr_reg_addr == 4'd1);
  assign wr_ok     = (32'(wr_sel) < MAP_CNT) && (32'(wr_off) < ADDR_BITS);
  assign wr_accept = wr_map & wr_ok;
  assign wr_reject = wr_map & ~wr_ok;

  assign vec_hit  = m2_fall && lat_rw && (lat_addr == 16'hFFFD) && saw_fffc;
  assign tmo_fire = (state == ST_PENDING) && (tmo_cnt == TMO_W'(SWITCH_TIMEOUT))
                    && !wr_accept && !vec_hit && !cpu_reset_rise;

  assign status_reg = {11'd0, 5'(select), ovr_cnt, rej_err, tmo_err, launcher_load, lstat};

  // M2 synchroniser and bus capture while M2 is high
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      m2_sync  <= '0;
      lat_addr <= '0;
      lat_data <= '0;
      lat_rw   <= 1'b0;
    end else begin
      m2_sync <= {m2_sync[1:0], m2};
      if (m2_sync[1]) begin
        lat_addr <= cpu_addr;
        lat_data <= cpu_data;
        lat_rw   <= cpu_rw;
      end
    end
  end

  // M2 idle counter for CPU reset detection
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      rst_cnt     <= '0;
      cpu_reset_q <= 1'b0;
    end else begin
      cpu_reset_q <= cpu_reset;
      if (m2_fall)
        rst_cnt <= '0;
      else if (!cpu_reset)
        rst_cnt <= rst_cnt + RST_W'(1);
    end
  end

  // FSM state register
  always_ff @(posedge clk) begin
    if (!reset_n) state <= ST_IDLE;
    else          state <= state_next;
  end

  // FSM next state: reset-vector fetch commits, timeout abandons, writes restage
  always_comb begin
    state_next = state;
    if (cpu_reset_rise) begin
      state_next = ST_IDLE;
    end else begin
      case (state)
        ST_IDLE:    if (wr_accept) state_next = ST_PENDING;
        ST_PENDING: begin
          if (wr_accept)     state_next = ST_PENDING;
          else if (vec_hit)  state_next = ST_COMMIT;
          else if (tmo_fire) state_next = ST_IDLE;
        end
        ST_COMMIT:  state_next = wr_accept ? ST_PENDING : ST_IDLE;
        default:    state_next = ST_IDLE;
      endcase
    end
  end

  // FSM outputs
  always_comb begin
    launcher_load = (state == ST_PENDING);
    do_commit     = (state == ST_COMMIT) && !cpu_reset_rise;
  end

  // Track the $FFFC half of the vector fetch across consecutive M2 cycles
  always_ff @(posedge clk) begin
    if (!reset_n || wr_accept || cpu_reset_rise)
      saw_fffc <= 1'b0;
    else if (m2_fall)
      saw_fffc <= lat_rw && (lat_addr == 16'hFFFC);
  end

  // Switch timeout counter, counts M2 cycles only while pending
  always_ff @(posedge clk) begin
    if (!reset_n || state != ST_PENDING || wr_accept)
      tmo_cnt <= '0;
    else if (m2_fall && tmo_cnt != TMO_W'(SWITCH_TIMEOUT))
      tmo_cnt <= tmo_cnt + TMO_W'(1);
  end

  // Staged mapper fields
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      stg_sel  <= '0;
      stg_off  <= '0;
      stg_args <= '0;
    end else if (wr_accept) begin
      stg_sel  <= wr_sel[MAP_BITS-1:0];
      stg_off  <= wr_off;
      stg_args <= wr_reg[11:10];
    end
  end

  // PRG mask / CHR base derived from the staged bank offset
  always_comb begin
    cm_mask = '1;
    cm_base = '0;
    if (stg_off != '0) begin
      cm_base = ADDR_BITS'(1) << stg_off;
      cm_mask = cm_base - ADDR_BITS'(1);
    end
  end

  // Active mapper registers: CPU reset restores the launcher layout
  always_ff @(posedge clk) begin
    if (!reset_n || cpu_reset_rise) begin
      select   <= '0;
      map_args <= '0;
      prg_mask <= '1;
      chr_base <= '0;
    end else if (do_commit) begin
      select   <= stg_sel;
      map_args <= stg_args;
      prg_mask <= cm_mask;
      chr_base <= cm_base;
    end
  end

  // Launcher controls; halt is a request cleared by the next M2 cycle
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      launcher_buffer_num <= 1'b0;
      launcher_halt       <= 1'b0;
    end else begin
      if (cpu_reset_rise)  launcher_buffer_num <= 1'b0;
      else if (wr_launch)  launcher_buffer_num <= wr_reg[0];
      if (wr_launch && wr_reg[1]) launcher_halt <= 1'b1;
      else if (m2_fall)           launcher_halt <= 1'b0;
    end
  end

  // Sticky error bits and launcher status capture
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      tmo_err <= 1'b0;
      rej_err <= 1'b0;
      lstat   <= '0;
    end else begin
      if (m2_fall) lstat <= launcher_status;
      if (wr_accept) begin
        tmo_err <= 1'b0;
        rej_err <= 1'b0;
      end else begin
        if (wr_reject) rej_err <= 1'b1;
        if (tmo_fire)  tmo_err <= 1'b1;
      end
    end
  end

  // Refresh request: delayed after M2 fall, held until ack, overruns counted
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      refresh_req <= 1'b0;
      dly_cnt     <= '0;
      ovr_cnt     <= '0;
    end else begin
      if (refresh_req && refresh_ack) refresh_req <= 1'b0;
      if (dly_cnt != '0) begin
        dly_cnt <= dly_cnt - DLY_W'(1);
        if (dly_cnt == DLY_W'(1)) refresh_req <= 1'b1;
      end
      if (m2_fall && select != '0) begin
        if (refresh_req) begin
          if (ovr_cnt != 4'hF) ovr_cnt <= ovr_cnt + 4'd1;
        end else if (dly_cnt == '0) begin
          dly_cnt <= DLY_W'(REFRESH_DELAY);
        end
      end
    end
  end

endmodule
